rv_decode_queue: RTL and testbench

//  Registered RV32I(+M) decode stage with an output queue; sits between fetch and dispatch.

---
 rtl/rv_decode_queue_pkg.sv | 87 ++++++++
 rtl/rv_decode_fifo.sv | 58 +++++
 rtl/rv_decode_queue.sv | 213 +++++++++++++++++++++
 tb/tb_rv_decode_queue.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_decode_queue_pkg.sv
// Shared types and constants for the RV32I(+M) decode queue.
// Holds opcode/funct constants, the M-extension match patterns, the mnemonic,
// operand-format and execution-unit enums, the decoded record struct and the
// immediate sign-extension helpers.
package rv_decode_queue_pkg;

  localparam int unsigned DEC_XLEN = 32;
  localparam int unsigned REG_W    = 5;

  localparam logic [31:0] HALT_INSTR = 32'h0001_0073;

  // Full R-type match mask (funct7, funct3, opcode)
  localparam logic [31:0] MASK_R   = 32'hFE00_707F;
  localparam logic [31:0] M_MUL    = 32'h0200_0033;
  localparam logic [31:0] M_MULH   = 32'h0200_1033;
  localparam logic [31:0] M_MULHSU = 32'h0200_2033;
  localparam logic [31:0] M_MULHU  = 32'h0200_3033;
  localparam logic [31:0] M_DIV    = 32'h0200_4033;
  localparam logic [31:0] M_DIVU   = 32'h0200_5033;
  localparam logic [31:0] M_REM    = 32'h0200_6033;
  localparam logic [31:0] M_REMU   = 32'h0200_7033;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // ILLEGAL is encoding 0 so an all-zero record reads as "nothing decoded"
  typedef enum logic [5:0] {
    ILLEGAL, LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LW, SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
    HALT
  } mnemonic_t;

  typedef enum logic [2:0] {OPT_NONE, OPT_R, OPT_I, OPT_S, OPT_B, OPT_U, OPT_J} optype_t;

  typedef enum logic [2:0] {NONE, ALU, BRU, MAU, MDU} proc_unit_t;

  typedef enum logic {RUN, HALTED} run_state_t;

  typedef struct packed {
    mnemonic_t            mnem;
    optype_t              optype;
    proc_unit_t           unit;
    logic [REG_W-1:0]     rd;
    logic [REG_W-1:0]     rs1;
    logic [REG_W-1:0]     rs2;
    logic [DEC_XLEN-1:0]  imm;
    logic [DEC_XLEN-1:0]  pc;
    logic                 illegal;
    logic                 is_halt;
  } decoded_instr_t;

  function automatic logic [DEC_XLEN-1:0] sext_i(input logic [31:0] ins);
    return DEC_XLEN'($signed(ins[31:20]));
  endfunction

  function automatic logic [DEC_XLEN-1:0] sext_s(input logic [31:0] ins);
    return DEC_XLEN'($signed({ins[31:25], ins[11:7]}));
  endfunction

  function automatic logic [DEC_XLEN-1:0] sext_b(input logic [31:0] ins);
    return DEC_XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
  endfunction

  function automatic logic [DEC_XLEN-1:0] sext_u(input logic [31:0] ins);
    return DEC_XLEN'($signed({ins[31:12], 12'b0}));
  endfunction

  function automatic logic [DEC_XLEN-1:0] sext_j(input logic [31:0] ins);
    return DEC_XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
  endfunction

endpackage

// File: rtl/rv_decode_fifo.sv
// Synchronous FIFO with flush for decoded records.
// Ports: clk, reset (async, high), flush (sync clear), push/wdata, pop/rdata,
// empty, full. rdata is the head entry, or zero while empty.
// Pushes into a full FIFO and pops from an empty one are ignored; flush wins.
module rv_decode_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rv_decode_queue.sv
// Registered RV32I(+M) decode stage with an output queue between fetch and dispatch.
// Ports: clk, reset (async, high), flush (sync clear, leaves HALTED);
// in_valid/in_ready/in_instr/in_pc from fetch; out_valid/out_ready/out_dec to
// dispatch; halted (HALT accepted, intake stalled); instr_count (accepts since
// reset or flush, wrapping).
module rv_decode_queue
  import rv_decode_queue_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 4,
  parameter bit          ENABLE_M = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic           out_valid,
  input  logic           out_ready,
  output decoded_instr_t out_dec,
  output logic           halted,
  output logic [XLEN-1:0] instr_count
);

  localparam int unsigned REC_W = $bits(decoded_instr_t);

  run_state_t     state;
  decoded_instr_t dec;
  logic           accept;
  logic           empty;
  logic           full;
  logic [REC_W-1:0] head;

  // Full decode of one instruction; non-matching encodings collapse to an ILLEGAL record
  function automatic decoded_instr_t decode(input logic [31:0] ins,
                                            input logic [DEC_XLEN-1:0] pc);
    decoded_instr_t d;
    logic           ok;
    logic [2:0]     f3;
    logic [6:0]     f7;
    f3       = ins[14:12];
    f7       = ins[31:25];
    ok       = 1'b1;
    d        = '0;
    d.pc     = pc;
    d.rd     = ins[11:7];
    d.rs1    = ins[19:15];
    d.rs2    = ins[24:20];
    d.mnem   = ILLEGAL;
    d.optype = OPT_NONE;
    d.unit   = NONE;
    if (ins == HALT_INSTR) begin
      d.rd      = '0;
      d.rs1     = '0;
      d.rs2     = '0;
      d.mnem    = HALT;
      d.is_halt = 1'b1;
    end else begin
      case (ins[6:0])
        OPC_LUI:   begin d.mnem = LUI;   d.optype = OPT_U; d.unit = ALU; end
        OPC_AUIPC: begin d.mnem = AUIPC; d.optype = OPT_U; d.unit = ALU; end
        OPC_JAL:   begin d.mnem = JAL;   d.optype = OPT_J; d.unit = BRU; end
        OPC_JALR: begin
          d.mnem = JALR; d.optype = OPT_I; d.unit = BRU;
          ok = (f3 == 3'd0);
        end
        OPC_BRANCH: begin
          d.optype = OPT_B; d.unit = BRU;
          case (f3)
            3'd0:    d.mnem = BEQ;
            3'd1:    d.mnem = BNE;
            3'd4:    d.mnem = BLT;
            3'd5:    d.mnem = BGE;
            3'd6:    d.mnem = BLTU;
            3'd7:    d.mnem = BGEU;
            default: ok = 1'b0;
          endcase
        end
        OPC_LOAD: begin
          d.optype = OPT_I; d.unit = MAU;
          case (f3)
            3'd0:    d.mnem = LB;
            3'd2:    d.mnem = LW;
            default: ok = 1'b0;
          endcase
        end
        OPC_STORE: begin
          d.optype = OPT_S; d.unit = MAU;
          case (f3)
            3'd0:    d.mnem = SB;
            3'd1:    d.mnem = SH;
            3'd2:    d.mnem = SW;
            default: ok = 1'b0;
          endcase
        end
        OPC_OPIMM: begin
          d.optype = OPT_I; d.unit = ALU;
          case (f3)
            3'd0: d.mnem = ADDI;
            3'd2: d.mnem = SLTI;
            3'd3: d.mnem = SLTIU;
            3'd4: d.mnem = XORI;
            3'd6: d.mnem = ORI;
            3'd7: d.mnem = ANDI;
            3'd1: begin d.mnem = SLLI; ok = (f7 == F7_BASE); end
            default: begin
              if (f7 == F7_BASE)     d.mnem = SRLI;
              else if (f7 == F7_ALT) d.mnem = SRAI;
              else                   ok = 1'b0;
            end
          endcase
        end
        OPC_OP: begin
          d.optype = OPT_R; d.unit = ALU;
          if (f7 == F7_BASE) begin
            case (f3)
              3'd0: d.mnem = ADD;
              3'd1: d.mnem = SLL;
              3'd2: d.mnem = SLT;
              3'd3: d.mnem = SLTU;
              3'd4: d.mnem = XOR;
              3'd5: d.mnem = SRL;
              3'd6: d.mnem = OR;
              default: d.mnem = AND;
            endcase
          end else if (f7 == F7_ALT) begin
            case (f3)
              3'd0:    d.mnem = SUB;
              3'd5:    d.mnem = SRA;
              default: ok = 1'b0;
            endcase
          end else if (f7 == F7_MULDIV && ENABLE_M) begin
            d.unit = MDU;
            case (ins & MASK_R)
              M_MUL:    d.mnem = MUL;
              M_MULH:   d.mnem = MULH;
              M_MULHSU: d.mnem = MULHSU;
              M_MULHU:  d.mnem = MULHU;
              M_DIV:    d.mnem = DIV;
              M_DIVU:   d.mnem = DIVU;
              M_REM:    d.mnem = REM;
              M_REMU:   d.mnem = REMU;
              default:  ok = 1'b0;
            endcase
          end else begin
            ok = 1'b0;
          end
        end
        default: ok = 1'b0;
      endcase

      // Zero register fields the format lacks and pick the immediate
      case (d.optype)
        OPT_I: begin d.rs2 = '0; d.imm = sext_i(ins); end
        OPT_S: begin d.rd = '0;  d.imm = sext_s(ins); end
        OPT_B: begin d.rd = '0;  d.imm = sext_b(ins); end
        OPT_U: begin d.rs1 = '0; d.rs2 = '0; d.imm = sext_u(ins); end
        OPT_J: begin d.rs1 = '0; d.rs2 = '0; d.imm = sext_j(ins); end
        default: ;
      endcase

      if (!ok) begin
        d         = '0;
        d.pc      = pc;
        d.mnem    = ILLEGAL;
        d.illegal = 1'b1;
      end
    end
    return d;
  endfunction

  always_comb begin
    dec = decode(in_instr, DEC_XLEN'(in_pc));
  end

  assign in_ready  = (state == RUN) && !full;
  assign accept    = in_valid && in_ready;
  assign out_valid = !empty;
  assign out_dec   = decoded_instr_t'(head);
  assign halted    = (state == HALTED);

  rv_decode_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (accept),
    .wdata (REC_W'(dec)),
    .pop   (out_ready),
    .rdata (head),
    .empty (empty),
    .full  (full)
  );

  // Run/halt state and accepted-instruction counter; flush overrides any accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      instr_count <= '0;
    end else if (flush) begin
      state       <= RUN;
      instr_count <= '0;
    end else if (accept) begin
      instr_count <= instr_count + 1'b1;
      if (dec.is_halt) state <= HALTED;
    end
  end

endmodule

// File: tb/tb_rv_decode_queue.sv
// Self-checking bench for rv_decode_queue: two instances (M extension off/on)
// share stimulus and are compared against a table-driven decode model and a
// queue model of the FIFO, halt and counter behaviour.
module tb_rv_decode_queue;
  import rv_decode_queue_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           flush;
  logic           in_valid;
  logic [31:0]    in_instr;
  logic [XLEN-1:0] in_pc;
  logic           out_ready;

  logic           in_ready0, in_ready1;
  logic           out_valid0, out_valid1;
  logic           halted0, halted1;
  decoded_instr_t dec0, dec1;
  logic [XLEN-1:0] cnt0, cnt1;

  always #5 clk = ~clk;

  rv_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .ENABLE_M(1'b0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid0), .out_ready(out_ready),
    .out_dec(dec0), .halted(halted0), .instr_count(cnt0));

  rv_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .ENABLE_M(1'b1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid1), .out_ready(out_ready),
    .out_dec(dec1), .halted(halted1), .instr_count(cnt1));

  int total = 0;
  int bad   = 0;

  // Reference model state
  decoded_instr_t q0[$];
  decoded_instr_t q1[$];
  bit             m_halted;
  logic [31:0]    m_cnt;

  // Encoding table: an instruction is legal if it matches exactly one (mask, match) row
  logic [31:0] t_mask  [64];
  logic [31:0] t_match [64];
  mnemonic_t   t_mn    [64];
  optype_t     t_fmt   [64];
  proc_unit_t  t_unit  [64];
  int          n_tab = 0;

  task automatic add(input logic [31:0] mask, input logic [31:0] match, input mnemonic_t mn,
                     input optype_t f, input proc_unit_t u);
    t_mask[n_tab] = mask; t_match[n_tab] = match; t_mn[n_tab] = mn;
    t_fmt[n_tab] = f; t_unit[n_tab] = u;
    n_tab++;
  endtask

  task automatic build_table();
    add(32'h7F, 32'h37, LUI, OPT_U, ALU);
    add(32'h7F, 32'h17, AUIPC, OPT_U, ALU);
    add(32'h7F, 32'h6F, JAL, OPT_J, BRU);
    add(32'h707F, 32'h67, JALR, OPT_I, BRU);
    add(32'h707F, 32'h0063, BEQ, OPT_B, BRU);
    add(32'h707F, 32'h1063, BNE, OPT_B, BRU);
    add(32'h707F, 32'h4063, BLT, OPT_B, BRU);
    add(32'h707F, 32'h5063, BGE, OPT_B, BRU);
    add(32'h707F, 32'h6063, BLTU, OPT_B, BRU);
    add(32'h707F, 32'h7063, BGEU, OPT_B, BRU);
    add(32'h707F, 32'h0003, LB, OPT_I, MAU);
    add(32'h707F, 32'h2003, LW, OPT_I, MAU);
    add(32'h707F, 32'h0023, SB, OPT_S, MAU);
    add(32'h707F, 32'h1023, SH, OPT_S, MAU);
    add(32'h707F, 32'h2023, SW, OPT_S, MAU);
    add(32'h707F, 32'h0013, ADDI, OPT_I, ALU);
    add(32'h707F, 32'h2013, SLTI, OPT_I, ALU);
    add(32'h707F, 32'h3013, SLTIU, OPT_I, ALU);
    add(32'h707F, 32'h4013, XORI, OPT_I, ALU);
    add(32'h707F, 32'h6013, ORI, OPT_I, ALU);
    add(32'h707F, 32'h7013, ANDI, OPT_I, ALU);
    add(32'hFE00707F, 32'h1013, SLLI, OPT_I, ALU);
    add(32'hFE00707F, 32'h5013, SRLI, OPT_I, ALU);
    add(32'hFE00707F, 32'h40005013, SRAI, OPT_I, ALU);
    add(32'hFE00707F, 32'h0033, ADD, OPT_R, ALU);
    add(32'hFE00707F, 32'h40000033, SUB, OPT_R, ALU);
    add(32'hFE00707F, 32'h1033, SLL, OPT_R, ALU);
    add(32'hFE00707F, 32'h2033, SLT, OPT_R, ALU);
    add(32'hFE00707F, 32'h3033, SLTU, OPT_R, ALU);
    add(32'hFE00707F, 32'h4033, XOR, OPT_R, ALU);
    add(32'hFE00707F, 32'h5033, SRL, OPT_R, ALU);
    add(32'hFE00707F, 32'h40005033, SRA, OPT_R, ALU);
    add(32'hFE00707F, 32'h6033, OR, OPT_R, ALU);
    add(32'hFE00707F, 32'h7033, AND, OPT_R, ALU);
    add(32'hFE00707F, 32'h02000033, MUL, OPT_R, MDU);
    add(32'hFE00707F, 32'h02001033, MULH, OPT_R, MDU);
    add(32'hFE00707F, 32'h02002033, MULHSU, OPT_R, MDU);
    add(32'hFE00707F, 32'h02003033, MULHU, OPT_R, MDU);
    add(32'hFE00707F, 32'h02004033, DIV, OPT_R, MDU);
    add(32'hFE00707F, 32'h02005033, DIVU, OPT_R, MDU);
    add(32'hFE00707F, 32'h02006033, REM, OPT_R, MDU);
    add(32'hFE00707F, 32'h02007033, REMU, OPT_R, MDU);
  endtask

  // Sign-extend the low 'bits' bits of v by subtracting 2^bits when the top bit is set
  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    logic [31:0] r;
    r = v;
    if (((v >> (bits - 1)) & 32'd1) != 0) r = v - (32'd1 << bits);
    return r;
  endfunction

  function automatic decoded_instr_t model_dec(input logic [31:0] ins, input logic [31:0] pc,
                                               input bit em);
    decoded_instr_t d;
    int hit;
    logic [31:0] v;
    d = '0;
    d.pc = pc;
    hit = -1;
    if (ins == 32'h0001_0073) begin
      d.mnem = HALT;
      d.is_halt = 1'b1;
      return d;
    end
    for (int k = 0; k < n_tab; k++)
      if ((ins & t_mask[k]) == t_match[k] && (em || t_unit[k] != MDU)) hit = k;
    if (hit < 0) begin
      d.mnem = ILLEGAL;
      d.illegal = 1'b1;
      return d;
    end
    d.mnem = t_mn[hit];
    d.optype = t_fmt[hit];
    d.unit = t_unit[hit];
    if (d.optype != OPT_S && d.optype != OPT_B) d.rd = ins[11:7];
    if (d.optype != OPT_U && d.optype != OPT_J) d.rs1 = ins[19:15];
    if (d.optype == OPT_R || d.optype == OPT_S || d.optype == OPT_B) d.rs2 = ins[24:20];
    case (d.optype)
      OPT_I: d.imm = sx(ins >> 20, 12);
      OPT_S: d.imm = sx(((ins >> 25) << 5) | ((ins >> 7) & 32'h1F), 12);
      OPT_B: begin
        v = (((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11)
          | (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
        d.imm = sx(v, 13);
      end
      OPT_U: d.imm = ins & 32'hFFFF_F000;
      OPT_J: begin
        v = (((ins >> 31) & 1) << 20) | (((ins >> 12) & 32'hFF) << 12)
          | (((ins >> 20) & 1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
        d.imm = sx(v, 21);
      end
      default: d.imm = '0;
    endcase
    return d;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // At a falling edge: compare all outputs with the model, advance the model
  // by the upcoming rising edge, then move to the next falling edge.
  task automatic cycle();
    decoded_instr_t e0, e1;
    logic rdy;
    rdy = !m_halted && (q0.size() < DEPTH);
    e0 = '0;
    e1 = '0;
    if (q0.size() != 0) begin e0 = q0[0]; e1 = q1[0]; end
    chk("in_ready", 128'(in_ready0), 128'(rdy));
    chk("in_ready_m", 128'(in_ready1), 128'(rdy));
    chk("out_valid", 128'(out_valid0), 128'(q0.size() != 0));
    chk("out_valid_m", 128'(out_valid1), 128'(q1.size() != 0));
    chk("out_dec", 128'(dec0), 128'(e0));
    chk("out_dec_m", 128'(dec1), 128'(e1));
    chk("halted", 128'(halted0), 128'(m_halted));
    chk("halted_m", 128'(halted1), 128'(m_halted));
    chk("instr_count", 128'(cnt0), 128'(m_cnt));
    chk("instr_count_m", 128'(cnt1), 128'(m_cnt));
    if (flush) begin
      q0.delete();
      q1.delete();
      m_cnt = '0;
      m_halted = 1'b0;
    end else begin
      if (out_ready && q0.size() != 0) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      if (in_valid && rdy) begin
        q0.push_back(model_dec(in_instr, in_pc, 1'b0));
        q1.push_back(model_dec(in_instr, in_pc, 1'b1));
        m_cnt = m_cnt + 1;
        if (in_instr == 32'h0001_0073) m_halted = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    int k;
    int r;
    r = $urandom_range(0, 19);
    if (r < 15) begin
      k = $urandom_range(0, n_tab - 1);
      return ($urandom & ~t_mask[k]) | t_match[k];
    end else if (r < 19) begin
      return $urandom;
    end
    return 32'h0001_0073;
  endfunction

  initial begin
    build_table();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    m_halted = 1'b0; m_cnt = '0;

    // Reset state
    #1;
    chk("rst_out_valid", 128'(out_valid0), 128'(0));
    chk("rst_out_dec", 128'(dec0), 128'(0));
    chk("rst_halted", 128'(halted0), 128'(0));
    chk("rst_count", 128'(cnt0), 128'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cycle();

    // ADDI x1,x0,-1
    in_valid = 1'b1; in_instr = 32'hFFF0_0093; in_pc = 32'h100; out_ready = 1'b1;
    cycle();
    chk("addi_valid", 128'(out_valid0), 128'(1));
    chk("addi_mnem", 128'(dec0.mnem), 128'(ADDI));
    chk("addi_unit", 128'(dec0.unit), 128'(ALU));
    chk("addi_rd", 128'(dec0.rd), 128'(1));
    chk("addi_rs1", 128'(dec0.rs1), 128'(0));
    chk("addi_imm", 128'(dec0.imm), 128'(32'hFFFF_FFFF));
    in_valid = 1'b0;
    cycle();

    // BEQ x1,x2,-8
    in_valid = 1'b1; in_instr = 32'hFE20_8CE3; in_pc = 32'h104;
    cycle();
    chk("beq_unit", 128'(dec0.unit), 128'(BRU));
    chk("beq_rs1", 128'(dec0.rs1), 128'(1));
    chk("beq_rs2", 128'(dec0.rs2), 128'(2));
    chk("beq_rd", 128'(dec0.rd), 128'(0));
    chk("beq_imm", 128'(dec0.imm), 128'(32'hFFFF_FFF8));
    // JAL x0,0
    in_instr = 32'h0000_006F; in_pc = 32'h108;
    cycle();
    chk("jal_mnem", 128'(dec0.mnem), 128'(JAL));
    chk("jal_imm", 128'(dec0.imm), 128'(0));
    in_valid = 1'b0;
    cycle();

    // Fill to full with back-to-back offers, then pop while offering
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_instr = rand_instr();
      if (in_instr == 32'h0001_0073) in_instr = 32'h0000_0013;
      in_pc = 32'h200 + 32'(i * 4);
      cycle();
      if (i == 3) chk("full_in_ready", 128'(in_ready0), 128'(0));
    end
    out_ready = 1'b1;
    cycle();
    chk("pop_at_full_ready", 128'(in_ready0), 128'(1));
    in_valid = 1'b0;
    repeat (4) cycle();

    // HALT stalls intake until flush
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0001_0073; in_pc = 32'h300;
    cycle();
    chk("halt_halted", 128'(halted0), 128'(1));
    chk("halt_is_halt", 128'(dec0.is_halt), 128'(1));
    in_instr = 32'h0000_0013;
    repeat (2) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_halted", 128'(halted0), 128'(0));
    chk("flush_valid", 128'(out_valid0), 128'(0));
    chk("flush_count", 128'(cnt0), 128'(0));

    // Illegal all-zero word, then MUL with and without the M extension
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0; in_pc = 32'h400;
    cycle();
    chk("zero_illegal", 128'(dec0.illegal), 128'(1));
    chk("zero_unit", 128'(dec0.unit), 128'(NONE));
    in_instr = 32'h0220_81B3;
    cycle();
    chk("mul_illegal_m0", 128'(dec0.illegal), 128'(1));
    chk("mul_unit_m1", 128'(dec1.unit), 128'(MDU));
    chk("mul_rd_m1", 128'(dec1.rd), 128'(3));
    chk("mul_mnem_m1", 128'(dec1.mnem), 128'(MUL));
    in_valid = 1'b0;
    cycle();

    // Asynchronous reset with three entries queued
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = 32'h0010_0093; in_pc = 32'h500 + 32'(i * 4);
      cycle();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("areset_valid", 128'(out_valid0), 128'(0));
    chk("areset_count", 128'(cnt0), 128'(0));
    chk("areset_valid_m", 128'(out_valid1), 128'(0));
    q0.delete(); q1.delete(); m_cnt = '0; m_halted = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cycle();

    // Flush and push in the same cycle drops the offered instruction
    in_valid = 1'b1; in_instr = 32'h0000_0033;
    cycle();
    flush = 1'b1; in_instr = 32'h0000_0013;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flushpush_valid", 128'(out_valid0), 128'(0));
    chk("flushpush_count", 128'(cnt0), 128'(0));
    cycle();

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      flush     = ($urandom_range(0, 39) == 0) || (m_halted && $urandom_range(0, 3) == 0);
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 1) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
